calc: RTL and testbench

- Two-operand decimal calculator with a 4-digit multiplexed seven-segment display driver.
- Operand A is two BCD digits (tens, units); operand B is two more BCD digits.
- One-hot operation buttons select add, subtract, multiply, divide or clear.
- The registered result is shown as a raw 7-bit value and on a 4-digit common-anode display.

---
 rtl/calc_pkg.sv | 44 ++++
 rtl/seg7_decoder.sv | 34 +++
 rtl/calc.sv | 154 +++++++++++++++
 tb/tb_calc.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types and constants for the BCD calculator: operation
//                encoding, seven-segment patterns and magnitude sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Operation selected by the one-hot button group
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4,
        OP_CLR  = 3'd5
    } op_e;

    // Largest magnitude the datapath can produce (99 * 99)
    localparam int MAX_MAG = 9801;
    localparam int MAG_W   = $clog2(MAX_MAG + 1);

    // Active-low segment patterns, left to right = a..g
    localparam logic [6:0] C_SEG_0    = 7'b0000001;
    localparam logic [6:0] C_SEG_1    = 7'b1001111;
    localparam logic [6:0] C_SEG_2    = 7'b0010010;
    localparam logic [6:0] C_SEG_3    = 7'b0000110;
    localparam logic [6:0] C_SEG_4    = 7'b1001100;
    localparam logic [6:0] C_SEG_5    = 7'b0100100;
    localparam logic [6:0] C_SEG_6    = 7'b0100000;
    localparam logic [6:0] C_SEG_7    = 7'b0001111;
    localparam logic [6:0] C_SEG_8    = 7'b0000000;
    localparam logic [6:0] C_SEG_9    = 7'b0000100;
    localparam logic [6:0] C_SEG_DASH = 7'b1111110;
    localparam logic [6:0] C_SEG_OFF  = 7'b1111111;

    // Saturate a keyed-in digit to the legal BCD range
    function automatic logic [3:0] clamp_digit(input logic [3:0] i_d);
        return (i_d > 4'd9) ? 4'd9 : i_d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : BCD digit to active-low seven-segment pattern (a..g).
//                Non-BCD codes blank the digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [0:6] o_seg
);

    // Pattern lookup for the selected digit
    always_comb begin
        o_seg = C_SEG_OFF;
        case (i_bcd)
            4'd0:    o_seg = C_SEG_0;
            4'd1:    o_seg = C_SEG_1;
            4'd2:    o_seg = C_SEG_2;
            4'd3:    o_seg = C_SEG_3;
            4'd4:    o_seg = C_SEG_4;
            4'd5:    o_seg = C_SEG_5;
            4'd6:    o_seg = C_SEG_6;
            4'd7:    o_seg = C_SEG_7;
            4'd8:    o_seg = C_SEG_8;
            4'd9:    o_seg = C_SEG_9;
            default: o_seg = C_SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/calc.sv
`default_nettype none
// ============================================================================
//  Module      : calc
//  Description : Two-operand decimal calculator (add/sub/mul/div/clear) with
//                a registered result and a 4-digit multiplexed common-anode
//                seven-segment display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc
    import calc_pkg::*;
#(
    parameter int CNT_W = 18
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] B1,
    input  logic [3:0] B2,
    input  logic [3:0] B3,
    input  logic [3:0] B4,
    input  logic       B5,
    input  logic       B6,
    input  logic       B7,
    input  logic       B8,
    input  logic       B9,
    output logic [0:6] result,
    output logic       dot,
    output logic [0:6] seg,
    output logic [0:3] en
);

    logic [MAG_W-1:0] r_mag;
    logic             r_neg;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [6:0]       w_a;
    logic [6:0]       w_b;
    op_e              w_op;
    logic [15:0]      w_bcd;
    logic [1:0]       w_sel;
    logic [3:0]       w_digit;
    logic [0:6]       w_dec_seg;

    // Operands: clamped BCD digit pairs folded to binary 0..99
    assign w_a = 7'(clamp_digit(B1)) * 7'd10 + 7'(clamp_digit(B2));
    assign w_b = 7'(clamp_digit(B3)) * 7'd10 + 7'(clamp_digit(B4));

    // Button priority encoder: add wins over everything below it
    always_comb begin
        w_op = OP_NONE;
        if (B5)      w_op = OP_ADD;
        else if (B6) w_op = OP_SUB;
        else if (B7) w_op = OP_MUL;
        else if (B8) w_op = OP_DIV;
        else if (B9) w_op = OP_CLR;
    end

    // Result registers and refresh counter; idle buttons hold the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag <= '0;
            r_neg <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            case (w_op)
                OP_ADD: begin
                    r_mag <= MAG_W'(w_a) + MAG_W'(w_b);
                    r_neg <= 1'b0;
                    r_err <= 1'b0;
                end
                OP_SUB: begin
                    if (w_a >= w_b) begin
                        r_mag <= MAG_W'(w_a - w_b);
                        r_neg <= 1'b0;
                    end else begin
                        r_mag <= MAG_W'(w_b - w_a);
                        r_neg <= 1'b1;
                    end
                    r_err <= 1'b0;
                end
                OP_MUL: begin
                    r_mag <= MAG_W'(w_a) * MAG_W'(w_b);
                    r_neg <= 1'b0;
                    r_err <= 1'b0;
                end
                OP_DIV: begin
                    r_neg <= 1'b0;
                    if (w_b == 7'd0) begin
                        r_mag <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_mag <= MAG_W'(w_a / w_b);
                        r_err <= 1'b0;
                    end
                end
                OP_CLR: begin
                    r_mag <= '0;
                    r_neg <= 1'b0;
                    r_err <= 1'b0;
                end
                default: begin
                    r_mag <= r_mag;
                    r_neg <= r_neg;
                    r_err <= r_err;
                end
            endcase
        end
    end

    // Binary to packed BCD (thousands in [15:12]) by shift-and-add-3
    always_comb begin
        w_bcd = '0;
        for (int i = MAG_W - 1; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (w_bcd[d*4 +: 4] >= 4'd5)
                    w_bcd[d*4 +: 4] = w_bcd[d*4 +: 4] + 4'd3;
            end
            w_bcd = {w_bcd[14:0], r_mag[i]};
        end
    end

    assign w_sel = r_cnt[CNT_W-1 -: 2];

    // Pick the digit for the currently enabled anode
    always_comb begin
        w_digit = w_bcd[15:12];
        case (w_sel)
            2'd0: w_digit = w_bcd[15:12];
            2'd1: w_digit = w_bcd[11:8];
            2'd2: w_digit = w_bcd[7:4];
            2'd3: w_digit = w_bcd[3:0];
            default: w_digit = w_bcd[15:12];
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    // One active-low anode; en[0] is the thousands position
    always_comb begin
        en        = 4'b1111;
        en[w_sel] = 1'b0;
    end

    assign seg    = r_err ? C_SEG_DASH : w_dec_seg;
    assign dot    = ~(r_neg & (w_sel == 2'd0));
    assign result = r_mag[6:0];

endmodule
`default_nettype wire

// File: tb/tb_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc
//  Description : Directed self-checking bench for calc with a result
//                scoreboard and a full display-refresh sweep after each step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc;

    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] B1 = '0, B2 = '0, B3 = '0, B4 = '0;
    logic       B5 = 1'b0, B6 = 1'b0, B7 = 1'b0, B8 = 1'b0, B9 = 1'b0;
    logic [0:6] result;
    logic       dot;
    logic [0:6] seg;
    logic [0:3] en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    mag;
        bit    neg;
        bit    err;
        string tag;
    } exp_t;

    exp_t q[$];

    logic [6:0] segtbl [10];
    logic [6:0] dash;

    // Reference refresh counter, advanced on the same edges as the design
    logic [CNT_W-1:0] tb_cnt = '0;

    calc #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .B1     (B1),
        .B2     (B2),
        .B3     (B3),
        .B4     (B4),
        .B5     (B5),
        .B6     (B6),
        .B7     (B7),
        .B8     (B8),
        .B9     (B9),
        .result (result),
        .dot    (dot),
        .seg    (seg),
        .en     (en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cnt <= rst ? '0 : tb_cnt + 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Pop the expected result and sweep every display position
    task automatic check_out();
        exp_t       e;
        int         dig [4];
        logic [1:0] sel;
        logic [3:0] exp_en;
        logic [6:0] exp_seg;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = q.pop_front();
        chk({e.tag, "_result"}, 32'(result), 32'(e.mag % 128));
        dig[0] = (e.mag / 1000) % 10;
        dig[1] = (e.mag / 100) % 10;
        dig[2] = (e.mag / 10) % 10;
        dig[3] = e.mag % 10;
        for (int k = 0; k < 16; k++) begin
            sel     = tb_cnt[CNT_W-1 -: 2];
            exp_en  = 4'b1111 ^ (4'b1000 >> sel);
            exp_seg = e.err ? dash : segtbl[dig[sel]];
            chk({e.tag, "_en"},  32'(en),  32'(exp_en));
            chk({e.tag, "_seg"}, 32'(seg), 32'(exp_seg));
            chk({e.tag, "_dot"}, 32'(dot), 32'((e.neg && sel == 2'd0) ? 1'b0 : 1'b1));
            @(negedge clk);
        end
    endtask

    // Drive one operation for a single cycle and record its expected outcome
    task automatic do_op(input logic [3:0] a1, a2, b1, b2, input logic [4:0] btn,
                         input int mag, input bit neg, input bit err, input string tag);
        exp_t e;
        @(negedge clk);
        B1 = a1; B2 = a2; B3 = b1; B4 = b2;
        {B5, B6, B7, B8, B9} = btn;
        e.mag = mag; e.neg = neg; e.err = err; e.tag = tag;
        q.push_back(e);
        @(negedge clk);
        {B5, B6, B7, B8, B9} = 5'b00000;
        check_out();
    endtask

    initial begin
        exp_t e;
        segtbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                   7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        dash   = 7'b1111110;

        // Reset state while rst is still high
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_en",     32'(en),     32'(4'b0111));
        chk("rst_seg",    32'(seg),    32'(7'b0000001));
        chk("rst_dot",    32'(dot),    32'd1);
        rst = 1'b0;
        e.mag = 0; e.neg = 0; e.err = 0; e.tag = "post_rst";
        q.push_back(e);
        check_out();

        //     B1    B2    B3    B4    B5..B9     mag  neg err tag
        do_op(4'd5, 4'd2, 4'd3, 4'd6, 5'b10000,   88, 0, 0, "add");
        do_op(4'd5, 4'd2, 4'd3, 4'd6, 5'b01000,   16, 0, 0, "sub_pos");
        do_op(4'd3, 4'd6, 4'd5, 4'd2, 5'b01000,   16, 1, 0, "sub_neg");
        do_op(4'd5, 4'd2, 4'd3, 4'd6, 5'b00100, 1872, 0, 0, "mul");
        do_op(4'd9, 4'd9, 4'd9, 4'd9, 5'b00100, 9801, 0, 0, "mul_max");
        do_op(4'd5, 4'd2, 4'd3, 4'd6, 5'b00010,    1, 0, 0, "div");
        do_op(4'd5, 4'd2, 4'd0, 4'd0, 5'b00010,    0, 0, 1, "div0");
        do_op(4'd5, 4'd2, 4'd0, 4'd0, 5'b10000,   52, 0, 0, "err_clr");
        do_op(4'd5, 4'd2, 4'd3, 4'd6, 5'b10100,   88, 0, 0, "prio");
        do_op(4'd5, 4'd2, 4'd3, 4'd6, 5'b00001,    0, 0, 0, "clear");
        do_op(4'd12, 4'd9, 4'd0, 4'd0, 5'b10000,  99, 0, 0, "clamp_a");
        do_op(4'd0, 4'd0, 4'd15, 4'd11, 5'b10000, 99, 0, 0, "clamp_b");

        // Reset together with a button: the operation is discarded
        @(negedge clk);
        rst = 1'b1; B1 = 4'd9; B2 = 4'd9; B3 = 4'd0; B4 = 4'd0; B5 = 1'b1;
        e.mag = 0; e.neg = 0; e.err = 0; e.tag = "rst_vs_add";
        q.push_back(e);
        @(negedge clk);
        rst = 1'b0; B5 = 1'b0;
        check_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
